// File: rtl/motoro3_line_param_seq.sv
// motoro3_line_param_seq
// Per-step line-parameter engine for the 3-phase motor line controller.
// A request latches the step settings, then a shift-add multiply and a
// restoring divide by 100 produce the scaled PWM on-length. The sine
// split-step length is a saturated shift of the step period. Results are
// registered and announced with a one-cycle lenValid pulse.

module motoro3_line_param_seq #(
    parameter int NSTEP   = 12,
    parameter int STEP_W  = 4,
    parameter int PCT_W   = 8,
    parameter int LEN_W   = 12,
    parameter int SPD_W   = 25,
    parameter int SPLIT_W = 2,
    parameter int OUT_W   = 16
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               calcReq,
    input  logic [STEP_W-1:0]  lcStep,
    input  logic [SPLIT_W-1:0] m3LpwmSplitStep,
    input  logic [SPLIT_W-1:0] m3r_stepSplitMax,
    input  logic [PCT_W-1:0]   m3r_power_percent,
    input  logic [LEN_W-1:0]   m3r_pwmLenWant,
    input  logic [LEN_W-1:0]   m3r_pwmMinMask,
    input  logic [SPD_W-1:0]   m3r_stepCNT_speedSET,
    output logic [OUT_W-1:0]   plLen,
    output logic [OUT_W-1:0]   slLen,
    output logic               lenValid,
    output logic               calcErr,
    output logic               busy,
    output logic               reqDrop
);

    localparam int PROD_W = LEN_W + PCT_W;
    localparam int CNT_W  = $clog2(PROD_W + 1);
    localparam int REM_W  = 8;

    localparam logic [REM_W-1:0]  DIVISOR = REM_W'(100);
    localparam logic [STEP_W:0]   NSTEP_V = (STEP_W + 1)'(NSTEP);
    localparam logic [PROD_W-1:0] PMAX    = PROD_W'((1 << OUT_W) - 1);
    localparam logic [SPD_W-1:0]  SMAX    = SPD_W'((1 << OUT_W) - 1);

    typedef enum logic [2:0] {IDLE, MUL, DIV, CLAMP, DONE} state_t;

    state_t state;
    state_t nextState;

    logic [STEP_W-1:0]  sStep;
    logic [SPLIT_W-1:0] sSplit;
    logic [SPLIT_W-1:0] sSplitMax;
    logic [PCT_W-1:0]   sPct;
    logic [LEN_W-1:0]   sWant;
    logic [LEN_W-1:0]   sMin;
    logic [SPD_W-1:0]   sSpeed;

    logic [PROD_W-1:0]  prod;
    logic [PROD_W-1:0]  mcand;
    logic [PCT_W-1:0]   mplier;
    logic [REM_W-1:0]   rem;
    logic [CNT_W-1:0]   cnt;
    logic               errFlag;

    logic [REM_W-1:0]   trial;
    logic               divBit;
    logic [REM_W-1:0]   divRem;
    logic [PROD_W-1:0]  pFloor;
    logic [OUT_W-1:0]   pSat;
    logic [SPD_W-1:0]   sShift;
    logic [OUT_W-1:0]   sSat;
    logic               calcBad;

    // State register; reset abandons any calculation in flight
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state sequencing: MUL spends one priming cycle plus PCT_W steps, DIV spends PROD_W steps
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (calcReq) nextState = MUL;
            MUL:     if (cnt == CNT_W'(PCT_W)) nextState = DIV;
            DIV:     if (cnt == CNT_W'(PROD_W - 1)) nextState = CLAMP;
            CLAMP:   nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Status outputs are decoded from the state so they can only pulse in DONE
    always_comb begin
        lenValid = (state == DONE);
        calcErr  = (state == DONE) && errFlag;
        busy     = (state != IDLE);
    end

    // One restoring-division step: shift the next dividend bit into the remainder and try to subtract 100
    always_comb begin
        trial  = {rem[REM_W-2:0], prod[PROD_W-1]};
        divBit = (trial >= DIVISOR);
        divRem = divBit ? (trial - DIVISOR) : trial;
    end

    // Floor, saturation and legality checks on the shadow copies for the CLAMP cycle
    always_comb begin
        pFloor  = (prod < PROD_W'(sMin)) ? PROD_W'(sMin) : prod;
        pSat    = (pFloor > PMAX) ? '1 : pFloor[OUT_W-1:0];
        sShift  = sSpeed >> sSplitMax;
        sSat    = (sShift > SMAX) ? '1 : sShift[OUT_W-1:0];
        calcBad = ({1'b0, sStep} >= NSTEP_V) || (sSplit > sSplitMax);
    end

    // Datapath: shadow capture, shift-add multiply, restoring divide, result registers and drop flag
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sStep     <= '0;
            sSplit    <= '0;
            sSplitMax <= '0;
            sPct      <= '0;
            sWant     <= '0;
            sMin      <= '0;
            sSpeed    <= '0;
            prod      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            cnt       <= '0;
            errFlag   <= 1'b0;
            plLen     <= '0;
            slLen     <= '0;
            reqDrop   <= 1'b0;
        end else begin
            reqDrop <= calcReq && (state != IDLE);
            case (state)
                IDLE: begin
                    if (calcReq) begin
                        sStep     <= lcStep;
                        sSplit    <= m3LpwmSplitStep;
                        sSplitMax <= m3r_stepSplitMax;
                        sPct      <= m3r_power_percent;
                        sWant     <= m3r_pwmLenWant;
                        sMin      <= m3r_pwmMinMask;
                        sSpeed    <= m3r_stepCNT_speedSET;
                        cnt       <= '0;
                    end
                end
                MUL: begin
                    if (cnt == '0) begin
                        prod   <= '0;
                        mcand  <= PROD_W'(sWant);
                        mplier <= sPct;
                    end else begin
                        if (mplier[0]) prod <= prod + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                    if (cnt == CNT_W'(PCT_W)) begin
                        cnt <= '0;
                        rem <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DIV: begin
                    rem  <= divRem;
                    prod <= {prod[PROD_W-2:0], divBit};
                    cnt  <= cnt + CNT_W'(1);
                end
                CLAMP: begin
                    errFlag <= calcBad;
                    if (!calcBad) begin
                        plLen <= pSat;
                        slLen <= sSat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motoro3_line_param_seq.sv
// tb_motoro3_line_param_seq
// Directed bench for the line-parameter engine with hand-computed results.

module tb_motoro3_line_param_seq;

    logic        clk;
    logic        nRst;
    logic        calcReq;
    logic [3:0]  lcStep;
    logic [1:0]  m3LpwmSplitStep;
    logic [1:0]  m3r_stepSplitMax;
    logic [7:0]  m3r_power_percent;
    logic [11:0] m3r_pwmLenWant;
    logic [11:0] m3r_pwmMinMask;
    logic [24:0] m3r_stepCNT_speedSET;
    logic [15:0] plLen;
    logic [15:0] slLen;
    logic        lenValid;
    logic        calcErr;
    logic        busy;
    logic        reqDrop;

    int checkCount = 0;
    int passCount  = 0;
    int cycleCount = 0;
    int acceptCycle = 0;
    int strayCount;

    motoro3_line_param_seq dut (
        .clk                  (clk),
        .nRst                 (nRst),
        .calcReq              (calcReq),
        .lcStep               (lcStep),
        .m3LpwmSplitStep      (m3LpwmSplitStep),
        .m3r_stepSplitMax     (m3r_stepSplitMax),
        .m3r_power_percent    (m3r_power_percent),
        .m3r_pwmLenWant       (m3r_pwmLenWant),
        .m3r_pwmMinMask       (m3r_pwmMinMask),
        .m3r_stepCNT_speedSET (m3r_stepCNT_speedSET),
        .plLen                (plLen),
        .slLen                (slLen),
        .lenValid             (lenValid),
        .calcErr              (calcErr),
        .busy                 (busy),
        .reqDrop              (reqDrop)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter used to measure latency from the accepting edge
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drive a request from a negedge; returns just after the accepting edge
    task automatic applyStimulus(input logic [11:0] want, input logic [7:0] pct,
                                 input logic [11:0] minm, input logic [1:0] split,
                                 input logic [1:0] smax, input logic [24:0] speed,
                                 input logic [3:0] step);
        m3r_pwmLenWant       = want;
        m3r_power_percent    = pct;
        m3r_pwmMinMask       = minm;
        m3LpwmSplitStep      = split;
        m3r_stepSplitMax     = smax;
        m3r_stepCNT_speedSET = speed;
        lcStep               = step;
        calcReq              = 1'b1;
        @(posedge clk);
        #1;
        acceptCycle = cycleCount;
        calcReq     = 1'b0;
    endtask

    // Wait, with a bound, for the lenValid cycle; sampled on negedges
    task automatic waitValid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (lenValid) seen = 1'b1;
        end
        if (!seen) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Full result check in the lenValid cycle, then confirm the following idle cycle
    task automatic checkDone(input string tag, input logic [15:0] expP,
                             input logic [15:0] expS, input logic expErr);
        checkOutput({tag, "_latency"}, 32'(cycleCount - acceptCycle), 32'd30);
        checkOutput({tag, "_plLen"}, 32'(plLen), 32'(expP));
        checkOutput({tag, "_slLen"}, 32'(slLen), 32'(expS));
        checkOutput({tag, "_calcErr"}, 32'(calcErr), 32'(expErr));
        checkOutput({tag, "_busyDone"}, 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput({tag, "_validLow"}, 32'(lenValid), 32'd0);
        checkOutput({tag, "_errLow"}, 32'(calcErr), 32'd0);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        nRst = 1'b0;
        calcReq = 1'b0;
        lcStep = '0;
        m3LpwmSplitStep = '0;
        m3r_stepSplitMax = '0;
        m3r_power_percent = '0;
        m3r_pwmLenWant = '0;
        m3r_pwmMinMask = '0;
        m3r_stepCNT_speedSET = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_plLen", 32'(plLen), 32'd0);
        checkOutput("rst_slLen", 32'(slLen), 32'd0);
        checkOutput("rst_lenValid", 32'(lenValid), 32'd0);
        checkOutput("rst_calcErr", 32'(calcErr), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_reqDrop", 32'(reqDrop), 32'd0);
        nRst = 1'b1;
        @(negedge clk);

        // T1: 1000*50/100 = 500, 40000 >> 0
        applyStimulus(12'd1000, 8'd50, 12'd64, 2'd0, 2'd0, 25'd40000, 4'd3);
        checkOutput("t1_busyAccept", 32'(busy), 32'd1);
        waitValid("t1");
        checkDone("t1", 16'd500, 16'd40000, 1'b0);

        // T2: 4095*255 = 1044225 -> 10442; 100*1/100 = 1 -> floored to 64
        applyStimulus(12'd4095, 8'd255, 12'd64, 2'd0, 2'd0, 25'd40000, 4'd3);
        waitValid("t2a");
        checkDone("t2a", 16'd10442, 16'd40000, 1'b0);
        applyStimulus(12'd100, 8'd1, 12'd64, 2'd0, 2'd0, 25'd40000, 4'd3);
        waitValid("t2b");
        checkDone("t2b", 16'd64, 16'd40000, 1'b0);

        // Zero percent gives the floor value
        applyStimulus(12'd1000, 8'd0, 12'd100, 2'd0, 2'd0, 25'd40000, 4'd3);
        waitValid("pct0");
        checkDone("pct0", 16'd100, 16'd40000, 1'b0);

        // T3: 200000 >> 2 = 50000 with split at its max; all-ones speed saturates; last legal step
        applyStimulus(12'd1000, 8'd50, 12'd64, 2'd2, 2'd2, 25'd200000, 4'd0);
        waitValid("t3a");
        checkDone("t3a", 16'd500, 16'd50000, 1'b0);
        applyStimulus(12'd1000, 8'd50, 12'd64, 2'd0, 2'd0, 25'h1FFFFFF, 4'd11);
        waitValid("t3b");
        checkDone("t3b", 16'd500, 16'd65535, 1'b0);

        // T4: illegal step, then split above its max; results hold 500/65535
        applyStimulus(12'd4095, 8'd255, 12'd64, 2'd0, 2'd0, 25'd40000, 4'd12);
        waitValid("t4a");
        checkDone("t4a", 16'd500, 16'd65535, 1'b1);
        applyStimulus(12'd4095, 8'd255, 12'd64, 2'd3, 2'd2, 25'd40000, 4'd0);
        waitValid("t4b");
        checkDone("t4b", 16'd500, 16'd65535, 1'b1);

        // T5: second request mid-calculation with new inputs is dropped
        applyStimulus(12'd1000, 8'd50, 12'd64, 2'd0, 2'd0, 25'd40000, 4'd3);
        repeat (10) @(negedge clk);
        m3r_pwmLenWant       = 12'd2000;
        m3r_power_percent    = 8'd100;
        m3r_stepCNT_speedSET = 25'd1000;
        calcReq = 1'b1;
        @(posedge clk);
        #1;
        calcReq = 1'b0;
        @(negedge clk);
        checkOutput("t5_reqDrop", 32'(reqDrop), 32'd1);
        @(negedge clk);
        checkOutput("t5_reqDropLow", 32'(reqDrop), 32'd0);
        waitValid("t5");
        checkDone("t5", 16'd500, 16'd40000, 1'b0);
        strayCount = 0;
        repeat (40) begin
            @(negedge clk);
            if (lenValid) strayCount++;
        end
        checkOutput("t5_singleValid", 32'(strayCount), 32'd0);

        // T6: reset mid-calculation clears outputs and suppresses the pulse
        @(negedge clk);
        applyStimulus(12'd2000, 8'd100, 12'd64, 2'd0, 2'd0, 25'd30000, 4'd3);
        repeat (15) @(negedge clk);
        nRst = 1'b0;
        #1;
        checkOutput("t6_plLen0", 32'(plLen), 32'd0);
        checkOutput("t6_slLen0", 32'(slLen), 32'd0);
        checkOutput("t6_busy0", 32'(busy), 32'd0);
        checkOutput("t6_valid0", 32'(lenValid), 32'd0);
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        strayCount = 0;
        repeat (40) begin
            @(negedge clk);
            if (lenValid) strayCount++;
        end
        checkOutput("t6_noStray", 32'(strayCount), 32'd0);
        applyStimulus(12'd1000, 8'd50, 12'd64, 2'd1, 2'd1, 25'd40000, 4'd5);
        waitValid("t6");
        checkDone("t6", 16'd500, 16'd20000, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
